tdc_ts_fifo: RTL

//  Timestamp buffer between the TDC capture core and the Wishbone slave of opentdc_wb.
//  - Accepts one {channel, coarse, fine} event per cycle from the TDC core.
//  - Stores events in a FIFO.
//  - Exposes status, pop and control registers to the Caravel management SoC over Wishbone.
//  - Counts events dropped when the FIFO is full.

---
 rtl/opentdc_pkg.sv | 39 +++
 rtl/tdc_ts_fifo_if.sv | 38 +++
 rtl/tdc_fifo_mem.sv | 29 ++
 rtl/tdc_ts_fifo.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/opentdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opentdc_pkg
//  Description : Shared constants and types for the opentdc timestamp FIFO:
//                Wishbone register addresses, STATUS bit positions and the
//                packed timestamp entry.
//  Revision    : 1.0  initial release
// ============================================================================
package opentdc_pkg;

    // Word addresses (wbs_adr_i[3:2])
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_POP    = 2'd1;
    localparam logic [1:0] REG_PEEK   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    // STATUS register layout
    localparam int STAT_DROP_LSB  = 16;
    localparam int STAT_FULL_BIT  = 15;
    localparam int STAT_EMPTY_BIT = 14;
    localparam int STAT_COUNT_W   = 7;

    // POP/PEEK "no data" flag
    localparam int POP_EMPTY_BIT  = 31;

    // Default field widths of a timestamp entry
    localparam int TS_NCH = 2;
    localparam int TS_FW  = 8;
    localparam int TS_CW  = 20;

    // Entry as stored and as returned in the low bits of POP/PEEK
    typedef struct packed {
        logic [TS_NCH-1:0] chan;
        logic [TS_FW-1:0]  fine;
        logic [TS_CW-1:0]  coarse;
    } ts_entry_t;

endpackage
`default_nettype wire

// File: rtl/tdc_ts_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_ts_fifo_if
//  Description : TDC event strobe plus Wishbone slave bus of the timestamp
//                FIFO. master = TDC core / SoC side, slave = FIFO side.
//  Revision    : 1.0  initial release
// ============================================================================
interface tdc_ts_fifo_if #(
    parameter int CW  = 20,
    parameter int FW  = 8,
    parameter int NCH = 2
);
    logic           ts_valid_i;
    logic [NCH-1:0] ts_chan_i;
    logic [CW-1:0]  ts_coarse_i;
    logic [FW-1:0]  ts_fine_i;
    logic           wbs_stb_i;
    logic           wbs_cyc_i;
    logic           wbs_we_i;
    logic [3:0]     wbs_sel_i;
    logic [3:0]     wbs_adr_i;
    logic [31:0]    wbs_dat_i;
    logic           wbs_ack_o;
    logic [31:0]    wbs_dat_o;

    modport master (
        output ts_valid_i, ts_chan_i, ts_coarse_i, ts_fine_i,
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  ts_valid_i, ts_chan_i, ts_coarse_i, ts_fine_i,
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/tdc_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_fifo_mem
//  Description : DEPTH x W register file, one synchronous write port and one
//                asynchronous read port. Contents are not reset; the FIFO
//                never reads a location it has not written.
//  Revision    : 1.0  initial release
// ============================================================================
module tdc_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 30
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [W-1:0]             i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/tdc_ts_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_ts_fifo
//  Description : Timestamp FIFO between the TDC capture core and the Wishbone
//                slave. Stores {chan,fine,coarse} events, counts drops when
//                full, exposes STATUS/POP/PEEK/THRESH registers.
//                Optional feature macro: TDC_FIFO_IRQ_EN (THRESH + irq_o).
//  Revision    : 1.0  initial release
// ============================================================================
module tdc_ts_fifo
    import opentdc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = TS_CW,
    parameter int FW    = TS_FW,
    parameter int NCH   = TS_NCH
) (
    input  wire logic    wb_clk_i,
    input  wire logic    wb_rst_n_i,
    tdc_ts_fifo_if.slave bus
`ifdef TDC_FIFO_IRQ_EN
    ,
    output logic         irq_o
`endif
);
    localparam int              c_aw      = $clog2(DEPTH);
    localparam int              c_ew      = NCH + FW + CW;
    localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = 1;
    localparam logic [c_aw:0]   c_cnt_one = 1;

    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [15:0]     r_drop;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic [c_ew-1:0] w_wr_entry, w_rd_entry;
    logic [31:0]     w_rdata;
    logic [STAT_COUNT_W-1:0] w_count7;
    logic [1:0]      w_addr;
    logic w_req, w_rd, w_wr, w_empty, w_full, w_pop, w_flush, w_clr, w_push, w_drop;

`ifdef TDC_FIFO_IRQ_EN
    logic [6:0] r_thresh;
    logic       r_irq;
    wire w_unused = &{1'b0, bus.wbs_sel_i, bus.wbs_adr_i[1:0], bus.wbs_dat_i[31:7]};
`else
    wire w_unused = &{1'b0, bus.wbs_sel_i, bus.wbs_adr_i[1:0], bus.wbs_dat_i[31:2]};
`endif

    // A new transaction is only accepted while no ack is outstanding
    assign w_req   = bus.wbs_stb_i & bus.wbs_cyc_i & ~r_ack;
    assign w_rd    = w_req & ~bus.wbs_we_i;
    assign w_wr    = w_req &  bus.wbs_we_i;
    assign w_addr  = bus.wbs_adr_i[3:2];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_count7 = STAT_COUNT_W'(r_count);

    // Flush beats a coincident push; a pop frees the slot a full-FIFO push needs
    assign w_pop   = w_rd & (w_addr == REG_POP) & ~w_empty;
    assign w_flush = w_wr & (w_addr == REG_STATUS) & bus.wbs_dat_i[0];
    assign w_clr   = w_wr & (w_addr == REG_STATUS) & bus.wbs_dat_i[1];
    assign w_push  = bus.ts_valid_i & ~w_flush & (~w_full | w_pop);
    assign w_drop  = bus.ts_valid_i & ~w_flush &  w_full & ~w_pop;

    assign w_wr_entry = {bus.ts_chan_i, bus.ts_fine_i, bus.ts_coarse_i};

    tdc_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (c_ew)
    ) u_mem (
        .clk     (wb_clk_i),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    // Register read mux, evaluated in the request cycle
    always_comb begin
        w_rdata = 32'h0;
        case (w_addr)
            REG_STATUS: begin
                w_rdata[STAT_DROP_LSB +: 16]    = r_drop;
                w_rdata[STAT_FULL_BIT]          = w_full;
                w_rdata[STAT_EMPTY_BIT]         = w_empty;
                w_rdata[STAT_COUNT_W-1:0]       = w_count7;
            end
            REG_POP, REG_PEEK: begin
                if (w_empty) w_rdata[POP_EMPTY_BIT] = 1'b1;
                else         w_rdata[c_ew-1:0]      = w_rd_entry;
            end
            default: begin
`ifdef TDC_FIFO_IRQ_EN
                w_rdata[6:0] = r_thresh;
`endif
            end
        endcase
    end

    // Pointers and occupancy
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating drop counter; a clear wins over a coincident drop
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i || w_clr)                  r_drop <= 16'h0;
        else if (w_drop && (r_drop != 16'hFFFF))   r_drop <= r_drop + 16'd1;
    end

    // Single-cycle ack with read data; data bus is zero outside read acks
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : 32'h0;
        end
    end

    assign bus.wbs_ack_o = r_ack;
    assign bus.wbs_dat_o = r_dat;

`ifdef TDC_FIFO_IRQ_EN
    // Threshold register and level interrupt, lagging the count by one cycle
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_thresh <= 7'd1;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_addr == REG_THRESH)) r_thresh <= bus.wbs_dat_i[6:0];
            r_irq <= (w_count7 >= r_thresh) && (r_thresh != 7'd0);
        end
    end

    assign irq_o = r_irq;
`endif
endmodule
`default_nettype wire
